mux_scan_collector: RTL and testbench



---
 rtl/kmachine_scan_pkg.sv | 14 +
 rtl/mux_scan_collector.sv | 117 +++++++++++
 tb/tb_mux_scan_collector.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/kmachine_scan_pkg.sv
// Shared types and constants for the dual 4-to-1 mux scan collector.
package kmachine_scan_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

  localparam int unsigned POS_W      = 2;
  localparam int unsigned WORD_W     = 4;
  localparam int unsigned HOLD_W     = 4;
  localparam int unsigned MAX_SETTLE = 15;

endpackage

// File: rtl/mux_scan_collector.sv
// Steps a dual 4-to-1 mux through its four positions, samples both outputs
// after SETTLE extra hold cycles each, and presents two assembled 4-bit words.
module mux_scan_collector
  import kmachine_scan_pkg::*;
#(
  parameter int unsigned SETTLE = 0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       CONT,
  input  logic       MASK_A,
  input  logic       MASK_B,
  input  logic       Ya,
  input  logic       Yb,
  output logic       S0,
  output logic       S1,
  output logic       Ea_N,
  output logic       Eb_N,
  output logic [3:0] Qa,
  output logic [3:0] Qb,
  output logic       BUSY,
  output logic       DONE
);

  if (SETTLE > MAX_SETTLE) begin : g_bad_settle
    $error("mux_scan_collector: SETTLE above MAX_SETTLE");
  end

  localparam logic [HOLD_W-1:0] SETTLE_H = HOLD_W'(SETTLE);

  state_e              state_q;
  logic [POS_W-1:0]    k_q;
  logic [HOLD_W-1:0]   hold_q;
  logic                ea_n_q, eb_n_q;
  logic [WORD_W-1:0]   wa_q, wb_q;
  logic [WORD_W-1:0]   qa_q, qb_q;
  logic                done_q;

  logic                ya_c, yb_c;
  logic [WORD_W-1:0]   wa_c, wb_c;
  logic                last_hold_c;

  // A disabled channel always reads 0, independent of what the pin shows.
  always_comb begin
    ya_c        = Ya & ~ea_n_q;
    yb_c        = Yb & ~eb_n_q;
    wa_c        = wa_q | (WORD_W'(ya_c) << k_q);
    wb_c        = wb_q | (WORD_W'(yb_c) << k_q);
    last_hold_c = (hold_q == SETTLE_H);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      hold_q  <= '0;
      ea_n_q  <= 1'b1;
      eb_n_q  <= 1'b1;
      wa_q    <= '0;
      wb_q    <= '0;
      qa_q    <= '0;
      qb_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (START) begin
            state_q <= ST_SCAN;
            k_q     <= '0;
            hold_q  <= '0;
            ea_n_q  <= MASK_A;
            eb_n_q  <= MASK_B;
            wa_q    <= '0;
            wb_q    <= '0;
          end
        end
        ST_SCAN: begin
          if (!last_hold_c) begin
            hold_q <= hold_q + HOLD_W'(1);
          end else if (&k_q) begin
            // Completion edge: publish words, then restart or return to idle.
            hold_q <= '0;
            k_q    <= '0;
            qa_q   <= wa_c;
            qb_q   <= wb_c;
            wa_q   <= '0;
            wb_q   <= '0;
            done_q <= 1'b1;
            if (!CONT) begin
              state_q <= ST_IDLE;
              ea_n_q  <= 1'b1;
              eb_n_q  <= 1'b1;
            end
          end else begin
            hold_q <= '0;
            k_q    <= k_q + POS_W'(1);
            wa_q   <= wa_c;
            wb_q   <= wb_c;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign S0   = k_q[1];
  assign S1   = k_q[0];
  assign Ea_N = ea_n_q;
  assign Eb_N = eb_n_q;
  assign Qa   = qa_q;
  assign Qb   = qb_q;
  assign BUSY = (state_q == ST_SCAN);
  assign DONE = done_q;

endmodule

// File: tb/tb_mux_scan_collector.sv
// Randomised and directed bench for mux_scan_collector, run at SETTLE=0 and SETTLE=2
// side by side, each against a cycle-count based behavioural model.
module tb_mux_scan_collector;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic START = 1'b0, CONT = 1'b0, MASK_A = 1'b0, MASK_B = 1'b0;
  logic [3:0] ia = 4'b0000, ib = 4'b0000;

  always #5 CLK = ~CLK;

  int vec = 0;
  int miss = 0;
  bit chk_en = 1'b0;

  // Two instances with different settle times; index 0 -> SETTLE=0, 1 -> SETTLE=2.
  logic       s0 [2], s1 [2], ea [2], eb [2], busy [2], done [2];
  logic [3:0] qa [2], qb [2];
  logic       ya [2], yb [2];

  // Mux models: a disabled channel drives 0, otherwise input I{S0,S1}.
  for (genvar g = 0; g < 2; g++) begin : g_mux
    assign ya[g] = ~ea[g] & ia[{s0[g], s1[g]}];
    assign yb[g] = ~eb[g] & ib[{s0[g], s1[g]}];
  end

  mux_scan_collector #(.SETTLE(0)) u_dut0 (
    .CLK(CLK), .RST(RST), .START(START), .CONT(CONT), .MASK_A(MASK_A), .MASK_B(MASK_B),
    .Ya(ya[0]), .Yb(yb[0]), .S0(s0[0]), .S1(s1[0]), .Ea_N(ea[0]), .Eb_N(eb[0]),
    .Qa(qa[0]), .Qb(qb[0]), .BUSY(busy[0]), .DONE(done[0])
  );

  mux_scan_collector #(.SETTLE(2)) u_dut2 (
    .CLK(CLK), .RST(RST), .START(START), .CONT(CONT), .MASK_A(MASK_A), .MASK_B(MASK_B),
    .Ya(ya[1]), .Yb(yb[1]), .S0(s0[1]), .S1(s1[1]), .Ea_N(ea[1]), .Eb_N(eb[1]),
    .Qa(qa[1]), .Qb(qb[1]), .BUSY(busy[1]), .DONE(done[1])
  );

  // Behavioural model: position and capture points follow from the cycle count since start.
  int         m_per [2] = '{1, 3};
  bit         m_busy [2];
  int         m_cyc [2];
  bit         m_ma [2], m_mb [2];
  logic [3:0] m_wa [2], m_wb [2], m_qa [2], m_qb [2];
  bit         m_done [2];

  always @(posedge CLK or posedge RST) begin
    for (int i = 0; i < 2; i++) begin
      if (RST) begin
        m_busy[i] = 0; m_cyc[i] = 0; m_ma[i] = 1; m_mb[i] = 1;
        m_wa[i] = '0; m_wb[i] = '0; m_qa[i] = '0; m_qb[i] = '0; m_done[i] = 0;
      end else if (m_busy[i]) begin
        int p, pos;
        p = m_per[i];
        pos = m_cyc[i] / p;
        m_done[i] = 0;
        if ((m_cyc[i] + 1) % p == 0) begin
          m_wa[i][pos] = ia[pos] & ~m_ma[i];
          m_wb[i][pos] = ib[pos] & ~m_mb[i];
        end
        if (m_cyc[i] + 1 == 4 * p) begin
          m_qa[i] = m_wa[i]; m_qb[i] = m_wb[i]; m_done[i] = 1;
          m_wa[i] = '0; m_wb[i] = '0; m_cyc[i] = 0;
          if (!CONT) begin
            m_busy[i] = 0; m_ma[i] = 1; m_mb[i] = 1;
          end
        end else begin
          m_cyc[i]++;
        end
      end else begin
        m_done[i] = 0;
        if (START) begin
          m_busy[i] = 1; m_cyc[i] = 0; m_ma[i] = MASK_A; m_mb[i] = MASK_B;
          m_wa[i] = '0; m_wb[i] = '0;
        end
      end
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge CLK) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        logic [13:0] act, exp;
        logic [1:0] pos;
        pos = m_busy[i] ? 2'(m_cyc[i] / m_per[i]) : 2'd0;
        exp = {pos, m_busy[i] ? m_ma[i] : 1'b1, m_busy[i] ? m_mb[i] : 1'b1,
               m_busy[i], m_done[i], m_qa[i], m_qb[i]};
        act = {s0[i], s1[i], ea[i], eb[i], busy[i], done[i], qa[i], qb[i]};
        vec++;
        if (act !== exp) begin
          miss++;
          $display("FAIL cycle_cmp dut%0d t=%0t got=%b want=%b (S0S1 EaEb BUSY DONE Qa Qb)",
                   i, $time, act, exp);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic wait_idle(output int n0, output int n2);
    n0 = 0; n2 = 0;
    for (int i = 0; i < 200; i++) begin
      if (busy[0]) n0++;
      if (busy[1]) n2++;
      if (!busy[0] && !busy[1]) return;
      @(negedge CLK);
    end
    miss++;
    vec++;
    $display("FAIL wait_idle timeout busy0=%b busy2=%b want 0", busy[0], busy[1]);
  endtask

  initial begin
    int n0, n2, ndone, t_first;
    logic [3:0] qseq [2];

    repeat (3) @(negedge CLK);
    chk_en = 1'b1;
    chk("reset_outputs", {s0[0], s1[0], ea[0], eb[0], busy[0], done[0], qa[0], qb[0]}, 14'b00110000000000);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    chk("idle_enables", {ea[0], eb[0], ea[1], eb[1]}, 4'b1111);

    // One-shot: I0..I3 a = 1,0,1,1 ; b = 0,1,1,0.
    ia = 4'b1101; ib = 4'b0110;
    pulse_start();
    wait_idle(n0, n2);
    chk("oneshot_busy_s0", n0, 4);
    chk("oneshot_busy_s2", n2, 12);
    chk("oneshot_qa_s0", qa[0], 4'b1101);
    chk("oneshot_qb_s0", qb[0], 4'b0110);
    chk("oneshot_qa_s2", qa[1], 4'b1101);
    chk("oneshot_qb_s2", qb[1], 4'b0110);

    // Channel B masked.
    MASK_B = 1'b1;
    pulse_start();
    MASK_B = 1'b0;
    wait_idle(n0, n2);
    chk("maskb_qa", qa[0], 4'b1101);
    chk("maskb_qb", qb[0], 4'b0000);
    chk("maskb_qb_s2", qb[1], 4'b0000);

    // Continuous mode with data change after first completion.
    CONT = 1'b1;
    pulse_start();
    ndone = 0; t_first = 0;
    for (int i = 0; i < 60 && ndone < 2; i++) begin
      if (done[0]) begin
        qseq[ndone] = qa[0];
        if (ndone == 0) begin
          t_first = i; ia = 4'b0010;
        end else begin
          chk("cont_done_gap", i - t_first, 4);
          CONT = 1'b0;
        end
        ndone++;
      end
      @(negedge CLK);
    end
    CONT = 1'b0;
    chk("cont_done_count", ndone, 2);
    chk("cont_qa_first", qseq[0], 4'b1101);
    chk("cont_qa_second", qseq[1], 4'b0010);
    wait_idle(n0, n2);

    // Reset in the middle of a scan at k=2.
    ia = 4'b1011; ib = 4'b1001;
    pulse_start();
    repeat (2) @(negedge CLK);
    chk("pre_rst_pos", {s0[0], s1[0]}, 2'b10);
    #2 RST = 1'b1;
    #1;
    chk("async_rst", {s0[0], s1[0], ea[0], eb[0], busy[0], done[0], qa[0], qb[0]}, 14'b00110000000000);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    pulse_start();
    wait_idle(n0, n2);
    chk("post_rst_qa", qa[0], 4'b1011);
    chk("post_rst_qb", qb[1], 4'b1001);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      START  = ($urandom_range(0, 3) == 0);
      CONT   = ($urandom_range(0, 2) == 0);
      MASK_A = ($urandom_range(0, 3) == 0);
      MASK_B = ($urandom_range(0, 3) == 0);
      ia     = 4'($urandom);
      ib     = 4'($urandom);
      @(negedge CLK);
    end
    START = 1'b0; CONT = 1'b0;
    wait_idle(n0, n2);
    @(negedge CLK);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
